ex_mem_port_arb: RTL and testbench

Arbiter for the single data SRAM port shared by the two EX issue slots of the dual-issue pipeline. When only one slot carries a memory access, that access goes straight to the port in the same cycle. When both slots carry one, the arbiter issues them over two consecutive cycles in program order, stalling the bundle for one cycle. It sits between the two execute sub-units and the data_sram_* outputs of EX, and drives the EX stall request to the stall controller.

---
 rtl/ex_mem_port_arb_pkg.sv | 20 ++
 rtl/ex_mem_port_arb_mem_req_buf.sv | 32 +++
 rtl/ex_mem_port_arb.sv | 125 ++++++++++++
 tb/tb_ex_mem_port_arb.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_port_arb_pkg.sv
// Shared types and constants for the EX data-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ex_mem_port_arb_pkg;

  // Arbiter FSM: IDLE issues directly, SECOND drains the buffered younger access.
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_SECOND = 1'b1
  } arb_state_e;

  // Width of a packed request {slot, wen[3:0], addr, wdata}.
  function automatic int mem_req_wd(input int addr_w, input int data_w);
    return 1 + 4 + addr_w + data_w;
  endfunction

  // Request width for the default 32-bit address / 32-bit data build.
  localparam int MEM_REQ_WD = mem_req_wd(32, 32);

endpackage

// File: rtl/ex_mem_port_arb_mem_req_buf.sv
// Holding register for the younger access of a dual-request bundle.
// Latency: load visible on dout the cycle after ld; clear/reset take effect next cycle.
// Backpressure: none; the owner decides when to load and clear.
module mem_req_buf
  import ex_mem_port_arb_pkg::*;
#(
  parameter int W = MEM_REQ_WD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] din,
  output logic         vld,
  output logic [W-1:0] dout
);

  // Capture on load; clear drops the valid bit and wipes the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (clr) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (ld) begin
      vld  <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/ex_mem_port_arb.sv
// Shares the single data SRAM port between the two EX slots; dual bundles issue in program order.
// Latency: single access 0 cycles; dual bundle issues older in cycle N, younger in N+1 (stallreq in N).
// Backpressure: hold freezes state and masks the port; flush kills current and buffered access.
// Optional ARB_PERF_EN adds conflict_cnt / access_cnt performance counters.
module ex_mem_port_arb
  import ex_mem_port_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              req0_en,
  input  logic [3:0]        req0_wen,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_en,
  input  logic [3:0]        req1_wen,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              order,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_wen,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [DATA_W-1:0] data_sram_wdata,
  output logic              grant_slot,
  output logic              stallreq
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       access_cnt
`endif
);

  localparam int REQ_W = mem_req_wd(ADDR_W, DATA_W);

  arb_state_e state_q, state_d;

  logic [REQ_W-1:0] req0_pkt, req1_pkt, older_pkt, younger_pkt;
  logic [REQ_W-1:0] buf_dout, port_pkt;
  logic             buf_vld, buf_ld, buf_clr, port_en;

  // Slot id travels with the request so MEM can route load data back.
  assign req0_pkt    = {1'b0, req0_wen, req0_addr, req0_wdata};
  assign req1_pkt    = {1'b1, req1_wen, req1_addr, req1_wdata};
  assign older_pkt   = order ? req1_pkt : req0_pkt;
  assign younger_pkt = order ? req0_pkt : req1_pkt;

  mem_req_buf #(.W(REQ_W)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .clr  (buf_clr),
    .ld   (buf_ld),
    .din  (younger_pkt),
    .vld  (buf_vld),
    .dout (buf_dout)
  );

  // Issue decision: rst > flush > hold > normal; port payload is zero whenever not enabled.
  always_comb begin
    state_d  = state_q;
    port_en  = 1'b0;
    port_pkt = '0;
    buf_ld   = 1'b0;
    buf_clr  = 1'b0;
    stallreq = 1'b0;
    if (rst) begin
      state_d = ARB_IDLE;
    end else if (flush) begin
      buf_clr = 1'b1;
      state_d = ARB_IDLE;
    end else if (!hold) begin
      case (state_q)
        ARB_IDLE: begin
          if (req0_en && req1_en) begin
            port_en  = 1'b1;
            port_pkt = older_pkt;
            buf_ld   = 1'b1;
            stallreq = 1'b1;
            state_d  = ARB_SECOND;
          end else if (req0_en) begin
            port_en  = 1'b1;
            port_pkt = req0_pkt;
          end else if (req1_en) begin
            port_en  = 1'b1;
            port_pkt = req1_pkt;
          end
        end
        ARB_SECOND: begin
          // Slot inputs are ignored here; the bundle is still held by last cycle's stall.
          port_en  = buf_vld;
          port_pkt = buf_vld ? buf_dout : '0;
          buf_clr  = 1'b1;
          state_d  = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  assign data_sram_en = port_en;
  assign {grant_slot, data_sram_wen, data_sram_addr, data_sram_wdata} = port_pkt;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

`ifdef ARB_PERF_EN
  // Performance counters: dual-request bundles and issued accesses, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
      access_cnt   <= '0;
    end else begin
      if (state_q == ARB_IDLE && state_d == ARB_SECOND) conflict_cnt <= conflict_cnt + 32'd1;
      if (port_en) access_cnt <= access_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_port_arb.sv
// Directed self-checking bench for ex_mem_port_arb.
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
// Counter checks compile in only when ARB_PERF_EN is defined.
module tb_ex_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst, flush, hold, order;
  logic        req0_en, req1_en;
  logic [3:0]  req0_wen, req1_wen;
  logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
  logic        data_sram_en, grant_slot, stallreq;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata;
`ifdef ARB_PERF_EN
  logic [31:0] conflict_cnt, access_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_port_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .hold            (hold),
    .req0_en         (req0_en),
    .req0_wen        (req0_wen),
    .req0_addr       (req0_addr),
    .req0_wdata      (req0_wdata),
    .req1_en         (req1_en),
    .req1_wen        (req1_wen),
    .req1_addr       (req1_addr),
    .req1_wdata      (req1_wdata),
    .order           (order),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .grant_slot      (grant_slot),
    .stallreq        (stallreq)
`ifdef ARB_PERF_EN
    ,
    .conflict_cnt    (conflict_cnt),
    .access_cnt      (access_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic en, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic gs, input logic st);
    chk({tag, ".en"},    64'(data_sram_en),    64'(en));
    chk({tag, ".wen"},   64'(data_sram_wen),   64'(wen));
    chk({tag, ".addr"},  64'(data_sram_addr),  64'(addr));
    chk({tag, ".wdata"}, 64'(data_sram_wdata), 64'(wdata));
    chk({tag, ".grant"}, 64'(grant_slot),      64'(gs));
    chk({tag, ".stall"}, 64'(stallreq),        64'(st));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req0_en = 0; req0_wen = 0; req0_addr = 0; req0_wdata = 0;
    req1_en = 0; req1_wen = 0; req1_addr = 0; req1_wdata = 0;
    order = 0; hold = 0; flush = 0;
  endtask

  task automatic dual(input logic [31:0] a0, input logic [31:0] a1, input logic ord);
    req0_en = 1; req0_wen = 0; req0_addr = a0; req0_wdata = 0;
    req1_en = 1; req1_wen = 0; req1_addr = a1; req1_wdata = 0;
    order = ord;
  endtask

  initial begin
    rst = 1;
    idle_in();
    cyc(); cyc();
    // Reset state
    rst = 0; #1;
    chk_port("reset", 0, 4'h0, 32'h0, 32'h0, 0, 0);
`ifdef ARB_PERF_EN
    chk("reset.conflict_cnt", 64'(conflict_cnt), 64'd0);
    chk("reset.access_cnt",   64'(access_cnt),   64'd0);
`endif

    // Single slot-0 load passes straight through
    cyc(); req0_en = 1; req0_addr = 32'h100; #1;
    chk_port("ld0", 1, 4'h0, 32'h100, 32'h0, 0, 0);

    // Single slot-1 store passes straight through
    cyc(); idle_in(); req1_en = 1; req1_wen = 4'h3; req1_addr = 32'h44; req1_wdata = 32'h55; #1;
    chk_port("st1", 1, 4'h3, 32'h44, 32'h55, 1, 0);

    // Dual, order=0: store then load to the same address
    cyc(); idle_in();
    req0_en = 1; req0_wen = 4'hF; req0_addr = 32'h200; req0_wdata = 32'hDEADBEEF;
    req1_en = 1; req1_wen = 4'h0; req1_addr = 32'h200; req1_wdata = 32'h0; #1;
    chk_port("dual0.N", 1, 4'hF, 32'h200, 32'hDEADBEEF, 0, 1);
    cyc(); req0_addr = 32'hBAD; req1_addr = 32'hBAD; #1;
    chk_port("dual0.N1", 1, 4'h0, 32'h200, 32'h0, 1, 0);
    cyc(); idle_in(); #1;
    chk_port("dual0.after", 0, 4'h0, 32'h0, 32'h0, 0, 0);

    // Dual, order=1: slot 1 is older
    cyc(); dual(32'h10, 32'h20, 1); #1;
    chk_port("dual1.N", 1, 4'h0, 32'h20, 32'h0, 1, 1);
    cyc(); #1;
    chk_port("dual1.N1", 1, 4'h0, 32'h10, 32'h0, 0, 0);

    // Dual then hold for three cycles during SECOND
    cyc(); idle_in(); dual(32'h30, 32'h34, 0); req1_wen = 4'hF; req1_wdata = 32'h1234; #1;
    chk_port("hold.N", 1, 4'h0, 32'h30, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); hold = 1; #1;
      chk_port("hold.frozen", 0, 4'h0, 32'h0, 32'h0, 0, 0);
    end
    cyc(); hold = 0; #1;
    chk_port("hold.release", 1, 4'hF, 32'h34, 32'h1234, 1, 0);
    cyc(); idle_in(); #1;
    chk_port("hold.once", 0, 4'h0, 32'h0, 32'h0, 0, 0);

    // Dual then flush in N+1: buffered access is dropped
    cyc(); dual(32'h40, 32'h44, 0); #1;
    chk_port("flush.N", 1, 4'h0, 32'h40, 32'h0, 0, 1);
    cyc(); flush = 1; #1;
    chk_port("flush.N1", 0, 4'h0, 32'h0, 32'h0, 0, 0);
    cyc(); idle_in(); req1_en = 1; req1_addr = 32'h60; #1;
    chk_port("flush.idle", 1, 4'h0, 32'h60, 32'h0, 1, 0);

    // Hold in IDLE with a dual bundle: nothing issues, then decision is re-evaluated
    cyc(); idle_in(); dual(32'h70, 32'h74, 0); hold = 1; #1;
    chk_port("holdidle.frozen", 0, 4'h0, 32'h0, 32'h0, 0, 0);
    cyc(); hold = 0; #1;
    chk_port("holdidle.N", 1, 4'h0, 32'h70, 32'h0, 0, 1);
    cyc(); idle_in(); #1;
    chk_port("holdidle.N1", 1, 4'h0, 32'h74, 32'h0, 1, 0);
    cyc(); #1;
    chk_port("holdidle.after", 0, 4'h0, 32'h0, 32'h0, 0, 0);

    // Reset while in SECOND discards the buffered access
    cyc(); dual(32'h80, 32'h84, 0); #1;
    chk_port("rstsec.N", 1, 4'h0, 32'h80, 32'h0, 0, 1);
    cyc(); idle_in(); rst = 1; #1;
    chk_port("rstsec.inrst", 0, 4'h0, 32'h0, 32'h0, 0, 0);
    cyc(); rst = 0; #1;
    chk_port("rstsec.after", 0, 4'h0, 32'h0, 32'h0, 0, 0);

`ifdef ARB_PERF_EN
    // Counters: 5 dual bundles (10 accesses) + 3 singles = 13 accesses
    cyc(); rst = 1;
    cyc(); rst = 0; #1;
    chk("perf.clr.conflict", 64'(conflict_cnt), 64'd0);
    chk("perf.clr.access",   64'(access_cnt),   64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(); dual(32'h100 + 32'(i), 32'h200 + 32'(i), 0);
      cyc(); idle_in();
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); idle_in(); req0_en = 1; req0_addr = 32'h300 + 32'(i);
    end
    cyc(); idle_in(); #1;
    chk("perf.conflict", 64'(conflict_cnt), 64'd5);
    chk("perf.access",   64'(access_cnt),   64'd13);
    cyc(); rst = 1;
    cyc(); rst = 0; #1;
    chk("perf.rst.conflict", 64'(conflict_cnt), 64'd0);
    chk("perf.rst.access",   64'(access_cnt),   64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
